// File: rtl/div_share_ctrl_if.sv
// Request, divider and response signals between div_share_ctrl and its environment.
interface div_share_ctrl_if #(
    parameter int unsigned W    = 8,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   req_ready;

    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_remainder;
    logic              rsp_dbz;

    // Environment side: requesters, response consumer and the shared divider.
    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder,
        input  req_ready, div_dividend, div_divisor,
               rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
    );

    // Controller side.
    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder,
        output req_ready, div_dividend, div_divisor,
               rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
    );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one combinational divider among NREQ requesters.
module div_share_ctrl #(
    parameter int unsigned W    = 8,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    div_share_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  gnt_q;
    logic [IDW-1:0]  gsel;
    logic            found;
    logic            accept;
    logic [NREQ-1:0] ready;
    logic [W-1:0]    sel_dividend;
    logic [W-1:0]    sel_divisor;
    logic [W-1:0]    dvd_q;
    logic [W-1:0]    dvs_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    rem_q;
    logic [IDW-1:0]  id_q;
    logic            vld_q;
    logic            dbz_q;

    // Round-robin pick: first valid requester after the last granted one.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found && bus.req_valid[(32'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                gsel  = IDW'((32'(ptr_q) + k) % NREQ);
            end
        end
        sel_dividend = bus.req_dividend[32'(gsel) * W +: W];
        sel_divisor  = bus.req_divisor[32'(gsel) * W +: W];
    end

    // Next state and the combinational one-hot acceptance strobe.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ready   = '0;
        case (state_q)
            IDLE: begin
                if (!rst && found) begin
                    accept  = 1'b1;
                    state_d = CALC;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        ready[i] = (gsel == IDW'(i));
                    end
                end
            end
            CALC: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, result capture (with local divide-by-zero) and response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDW'(NREQ - 1);
            gnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            id_q  <= '0;
            vld_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            if (accept) begin
                dvd_q <= sel_dividend;
                dvs_q <= sel_divisor;
                gnt_q <= gsel;
                ptr_q <= gsel;
            end
            if (state_q == CALC) begin
                if (dvs_q != '0) begin
                    quo_q <= bus.div_quotient;
                    rem_q <= bus.div_remainder;
                    dbz_q <= 1'b0;
                end else begin
                    quo_q <= '1;
                    rem_q <= dvd_q;
                    dbz_q <= 1'b1;
                end
                id_q  <= gnt_q;
                vld_q <= 1'b1;
            end
            if (state_q == RESP && bus.rsp_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready     = ready;
    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;
    assign bus.rsp_valid     = vld_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_dbz       = dbz_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed self-checking bench for div_share_ctrl with a behavioural divider.
module tb_div_share_ctrl;
    localparam int unsigned W    = 8;
    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_share_ctrl_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

    div_share_ctrl #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Divider stand-in; returns junk on a zero divisor so that must be ignored.
    assign bus.div_quotient  = (bus.div_divisor == 8'd0) ? 8'h5A : bus.div_dividend / bus.div_divisor;
    assign bus.div_remainder = (bus.div_divisor == 8'd0) ? 8'hA5 : bus.div_dividend % bus.div_divisor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation from requester i, starting and ending in IDLE.
    task automatic single_op(input int i, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        bus.req_valid = '0;
        bus.req_valid[i] = 1'b1;
        bus.req_dividend[i*W +: W] = a;
        bus.req_divisor[i*W +: W]  = b;
        #1;
        chk("acc_ready", 32'(bus.req_ready), 32'(2'b01 << i));
        tick();
        bus.req_valid = '0;
        #1;
        chk("calc_dvd", 32'(bus.div_dividend), 32'(a));
        chk("calc_dvs", 32'(bus.div_divisor), 32'(b));
        chk("calc_vld", 32'(bus.rsp_valid), 32'(0));
        chk("calc_rdy", 32'(bus.req_ready), 32'(0));
        tick();
        chk("rsp_vld", 32'(bus.rsp_valid), 32'(1));
        chk("rsp_id", 32'(bus.rsp_id), 32'(i));
        chk("rsp_q", 32'(bus.rsp_quotient), 32'(eq));
        chk("rsp_r", 32'(bus.rsp_remainder), 32'(er));
        chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(edbz));
        tick();
        chk("ret_idle", 32'(bus.rsp_valid), 32'(0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid    = 2'b11;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b1;
        repeat (2) tick();

        // Reset state; req_ready must stay low while rst is high.
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_vld", 32'(bus.rsp_valid), 32'(0));
        chk("rst_id", 32'(bus.rsp_id), 32'(0));
        chk("rst_q", 32'(bus.rsp_quotient), 32'(0));
        chk("rst_r", 32'(bus.rsp_remainder), 32'(0));
        chk("rst_dbz", 32'(bus.rsp_dbz), 32'(0));
        chk("rst_dvd", 32'(bus.div_dividend), 32'(0));
        chk("rst_dvs", 32'(bus.div_divisor), 32'(0));
        rst = 1'b0;
        bus.req_valid = '0;

        // Single op, divide by zero, edge operands.
        single_op(0, 8'd133, 8'd17, 8'd7, 8'd14, 1'b0);
        single_op(1, 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
        single_op(0, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        single_op(1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        single_op(0, 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
        single_op(1, 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);

        // Contention: both requesters held valid, grants alternate 0,1,0,1.
        bus.req_dividend = {8'd255, 8'd100};
        bus.req_divisor  = {8'd16, 8'd7};
        bus.req_valid    = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("rr_ready", 32'(bus.req_ready), (n % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
            tick();
            tick();
            chk("rr_vld", 32'(bus.rsp_valid), 32'(1));
            chk("rr_id", 32'(bus.rsp_id), 32'(n % 2));
            chk("rr_q", 32'(bus.rsp_quotient), (n % 2 == 0) ? 32'(14) : 32'(15));
            chk("rr_r", 32'(bus.rsp_remainder), (n % 2 == 0) ? 32'(2) : 32'(15));
            tick();
        end

        // Backpressure: response frozen for 5 cycles, req1 waits.
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_acc", 32'(bus.req_ready), 32'(2'b01));
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_vld", 32'(bus.rsp_valid), 32'(1));
            chk("bp_id", 32'(bus.rsp_id), 32'(0));
            chk("bp_q", 32'(bus.rsp_quotient), 32'(14));
            chk("bp_r", 32'(bus.rsp_remainder), 32'(2));
            chk("bp_ready", 32'(bus.req_ready), 32'(0));
            if (c < 4) tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("hs_noacc", 32'(bus.req_ready), 32'(0));
        tick();
        chk("hs_vld", 32'(bus.rsp_valid), 32'(0));
        chk("hs_acc1", 32'(bus.req_ready), 32'(2'b10));
        tick();
        tick();
        chk("bp1_id", 32'(bus.rsp_id), 32'(1));
        chk("bp1_q", 32'(bus.rsp_quotient), 32'(15));
        chk("bp1_r", 32'(bus.rsp_remainder), 32'(15));
        tick();

        // Reset during CALC discards the op and restores requester-0 priority.
        bus.req_valid = 2'b01;
        #1;
        chk("mr_acc", 32'(bus.req_ready), 32'(2'b01));
        tick();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("mr_rdy_rst", 32'(bus.req_ready), 32'(0));
        tick();
        chk("mr_vld", 32'(bus.rsp_valid), 32'(0));
        chk("mr_dvd", 32'(bus.div_dividend), 32'(0));
        chk("mr_q", 32'(bus.rsp_quotient), 32'(0));
        rst = 1'b0;
        #1;
        chk("mr_first", 32'(bus.req_ready), 32'(2'b01));
        tick();
        chk("mr_calc_vld", 32'(bus.rsp_valid), 32'(0));
        tick();
        chk("mr_rsp_vld", 32'(bus.rsp_valid), 32'(1));
        chk("mr_rsp_id", 32'(bus.rsp_id), 32'(0));
        chk("mr_rsp_q", 32'(bus.rsp_quotient), 32'(14));
        bus.req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencing and arbitration controller that lets NREQ requesters share one combinational 8-bit divider (the team's Division_comb).
- Accepts divide requests over a valid/ready handshake and picks one requester at a time, round-robin.
- Drives the held operands into the external divider and waits one settling cycle.
- Returns the quotient and remainder tagged with the requester ID. Divide-by-zero is handled locally.

Parameters:
- W, 8, operand/result width; must match the divider instance.
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_dividend  in  NREQ*W  packed dividends; requester i uses bits [i*W +: W].
- req_divisor  in  NREQ*W  packed divisors, same packing.
- req_ready  out  NREQ  one-hot acceptance strobe.
- div_dividend  out  W  dividend driven to the divider.
- div_divisor  out  W  divisor driven to the divider.
- div_quotient  in  W  quotient returned by the divider.
- div_remainder  in  W  remainder returned by the divider.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns this response.
- rsp_quotient  out  W  registered quotient.
- rsp_remainder  out  W  registered remainder.
- rsp_dbz  out  1  set when the divisor was zero.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0.
  - div_dividend=0, div_divisor=0.
  - RR pointer=NREQ-1, so requester 0 has first priority after reset.
  - req_ready=0 while rst=1.
- Reset asserted mid-operation discards the in-flight op. No response is produced for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Selected requester g is the first i with req_valid[i]=1, scanning from pointer+1 modulo NREQ.
  - req_ready[g]=1 combinationally in that same cycle; all other req_ready bits are 0.
  - On that edge: latch operands[g] into div_dividend/div_divisor, latch g, pointer<=g, go to CALC.
  - req_ready is 0 in every state except IDLE.
  - With no req_valid set, the FSM stays in IDLE.
- CALC (exactly 1 cycle): div_* stays stable. On the edge:
  - If the latched divisor != 0: rsp_quotient<=div_quotient, rsp_remainder<=div_remainder, rsp_dbz<=0.
  - If the latched divisor == 0: rsp_quotient<=all ones, rsp_remainder<=latched dividend, rsp_dbz<=1. The divider outputs are ignored.
  - rsp_id<=g, rsp_valid<=1, go to RESP.
- RESP:
  - All rsp_* outputs are held stable until the cycle in which rsp_valid && rsp_ready.
  - On that edge: rsp_valid<=0, go to IDLE.
  - No new acceptance happens in the same cycle as the response handshake.
- div_dividend/div_divisor hold their last value outside CALC. They change only on acceptance.
- Latency: acceptance in cycle T gives rsp_valid=1 from cycle T+2. Best-case throughput is one op per 3 cycles.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees req_ready. The controller relies on this.
  - A requester may drop req_valid before it is granted. This has no effect on the controller.
  - A granted requester may re-assert req_valid immediately. It is not served again until the other valid requesters have had a turn (round-robin fairness).
- Simultaneous requests: the RR order decides. Starvation bound: NREQ-1 other grants.
- Arithmetic: unsigned, W bits. The divider result is taken as-is, with no width extension.

Test Plan:
- Single op: req0 sends dividend 133 (8'h85), divisor 17 (8'h11) -> req_ready[0] pulses in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, quotient=7, remainder=14, dbz=0.
- Divide by zero: req1 sends 200/0 -> rsp_quotient=8'hFF, rsp_remainder=200, rsp_dbz=1, rsp_id=1.
- Contention: req0 and req1 both hold valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; each response carries the matching id and operands (e.g. 100/7 -> 14 r 2; 255/16 -> 15 r 15).
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> outputs stay frozen; req_ready stays 0; the pending req1 is accepted only in the cycle after the rsp handshake.
- Reset mid-op: assert rst in CALC -> next cycle rsp_valid=0 and state is IDLE; after release, with both requesters valid, req0 is granted first.
- Edge operands: 5/9 -> q=0, r=5; 255/1 -> q=255, r=0; 0/3 -> q=0, r=0.
